// File: rtl/dcc_pkg.sv
// Shared DCC definitions: half-bit classes, decoder states and the nominal
// timing constants that both the track encoder and the decoder build from.
package dcc_pkg;

   typedef enum logic [1:0] {HC_ONE, HC_ZERO, HC_BAD} half_class_t;
   typedef enum logic [1:0] {HUNT, DATA, SEP, HOLD} dec_state_t;

   // Nominal half-bit widths in clk cycles at 1 MHz.
   localparam int DCC_HALF_ONE_US   = 58;
   localparam int DCC_HALF_ZERO_US  = 100;

   localparam int DCC_HALF_ONE_MIN  = 52;
   localparam int DCC_HALF_ONE_MAX  = 64;
   localparam int DCC_HALF_ZERO_MIN = 90;
   localparam int DCC_HALF_ZERO_MAX = 10000;
   localparam int DCC_PREAMBLE_MIN  = 10;
   localparam int DCC_MAX_BYTES     = 6;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
      return (en && v != 16'hFFFF) ? v + 16'd1 : v;
   endfunction

endpackage

// File: rtl/dcc_half_meter.sv
// Track input front end: 2-flop synchroniser, either-edge detect, 14-bit
// saturating width counter and ONE/ZERO/BAD classification of each half-bit.
module dcc_half_meter
   import dcc_pkg::*;
#(
   parameter int HALF_ONE_MIN  = DCC_HALF_ONE_MIN,
   parameter int HALF_ONE_MAX  = DCC_HALF_ONE_MAX,
   parameter int HALF_ZERO_MIN = DCC_HALF_ZERO_MIN,
   parameter int HALF_ZERO_MAX = DCC_HALF_ZERO_MAX
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       track_in,
   output logic       half_strobe,
   output logic [1:0] half_class
);

   localparam logic [13:0] ONE_MIN  = 14'(HALF_ONE_MIN);
   localparam logic [13:0] ONE_MAX  = 14'(HALF_ONE_MAX);
   localparam logic [13:0] ZERO_MIN = 14'(HALF_ZERO_MIN);
   localparam logic [13:0] ZERO_MAX = 14'(HALF_ZERO_MAX);

   logic        sync0_q, sync0_d;
   logic        sync1_q, sync1_d;
   logic        prev_q, prev_d;
   logic        seen_q, seen_d;
   logic [13:0] cnt_q, cnt_d;
   logic        strobe_q, strobe_d;
   half_class_t class_q, class_d;
   logic        edge_det;

   assign edge_det = sync1_q ^ prev_q;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      sync0_d  = track_in;
      sync1_d  = sync0_q;
      prev_d   = sync1_q;
      seen_d   = seen_q;
      strobe_d = 1'b0;
      class_d  = class_q;
      cnt_d    = (cnt_q == 14'h3FFF) ? cnt_q : cnt_q + 14'd1;
      if (edge_det) begin
         // Restart at 1 so the count seen at the next edge equals the width in cycles.
         cnt_d  = 14'd1;
         seen_d = 1'b1;
         if (seen_q) begin
            strobe_d = 1'b1;
            if (cnt_q >= ONE_MIN && cnt_q <= ONE_MAX)
               class_d = HC_ONE;
            else if (cnt_q >= ZERO_MIN && cnt_q <= ZERO_MAX)
               class_d = HC_ZERO;
            else
               class_d = HC_BAD;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync0_q  <= 1'b0;
         sync1_q  <= 1'b0;
         prev_q   <= 1'b0;
         seen_q   <= 1'b0;
         cnt_q    <= '0;
         strobe_q <= 1'b0;
         class_q  <= HC_BAD;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         sync0_q  <= sync0_d;
         sync1_q  <= sync1_d;
         prev_q   <= prev_d;
         seen_q   <= seen_d;
         cnt_q    <= cnt_d;
         strobe_q <= strobe_d;
         class_q  <= class_d;
      end
   end

   assign half_strobe = strobe_q;
   assign half_class  = class_q;

endmodule

// File: rtl/dcc_decoder.sv
// DCC receive decoder: pairs half-bits into bits, hunts the preamble, frames
// bytes, checks the XOR byte and presents packets on valid/ready.
// Define DCC_DECODER_STATS_EN to add the stat_good/stat_csum/stat_frame counters.
module dcc_decoder
   import dcc_pkg::*;
#(
   parameter int HALF_ONE_MIN  = DCC_HALF_ONE_MIN,
   parameter int HALF_ONE_MAX  = DCC_HALF_ONE_MAX,
   parameter int HALF_ZERO_MIN = DCC_HALF_ZERO_MIN,
   parameter int HALF_ZERO_MAX = DCC_HALF_ZERO_MAX,
   parameter int PREAMBLE_MIN  = DCC_PREAMBLE_MIN,
   parameter int MAX_BYTES     = DCC_MAX_BYTES
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   track_in,
   output logic                   pkt_valid,
   input  logic                   pkt_ready,
   output logic [8*MAX_BYTES-1:0] pkt_data,
   output logic [2:0]             pkt_len,
   output logic                   err_pulse
`ifdef DCC_DECODER_STATS_EN
   ,
   output logic [15:0]            stat_good,
   output logic [15:0]            stat_csum,
   output logic [15:0]            stat_frame
`endif
);

   localparam logic [2:0] MAXB    = 3'(MAX_BYTES);
   localparam logic [4:0] PRE_MIN = 5'(PREAMBLE_MIN);

   logic        half_strobe;
   logic [1:0]  half_class_raw;
   half_class_t hc;

   dcc_half_meter #(
      .HALF_ONE_MIN  (HALF_ONE_MIN),
      .HALF_ONE_MAX  (HALF_ONE_MAX),
      .HALF_ZERO_MIN (HALF_ZERO_MIN),
      .HALF_ZERO_MAX (HALF_ZERO_MAX)
   ) u_meter (
      .clk         (clk),
      .reset_n     (reset_n),
      .track_in    (track_in),
      .half_strobe (half_strobe),
      .half_class  (half_class_raw)
   );

   assign hc = half_class_t'(half_class_raw);

   dec_state_t             state_q, state_d;
   logic                   have_first_q, have_first_d;
   half_class_t            first_q, first_d;
   logic [4:0]             ones_q, ones_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [2:0]             idx_q, idx_d;
   logic [7:0]             shift_q, shift_d;
   logic [7:0]             xor_q, xor_d;
   logic [8*MAX_BYTES-1:0] buf_q, buf_d;
   logic                   out_valid_q, out_valid_d;
   logic [8*MAX_BYTES-1:0] out_data_q, out_data_d;
   logic [2:0]             out_len_q, out_len_d;
   logic                   err_q, err_d;

   logic       bit_v, bit_val, bad_half;
   logic       pkt_done, frame_err, csum_err, load, drop;
   logic [2:0] idx_next;

   assign idx_next = idx_q + 3'd1;

   // Half pairing: a mismatched second half becomes the new first half.
   always_comb begin
      bit_v        = 1'b0;
      bit_val      = 1'b0;
      bad_half     = 1'b0;
      have_first_d = have_first_q;
      first_d      = first_q;
      if (half_strobe) begin
         if (hc == HC_BAD) begin
            bad_half     = 1'b1;
            have_first_d = 1'b0;
         end else if (!have_first_q) begin
            have_first_d = 1'b1;
            first_d      = hc;
         end else if (hc == first_q) begin
            bit_v        = 1'b1;
            bit_val      = (hc == HC_ONE);
            have_first_d = 1'b0;
         end else begin
            first_d = hc;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ones_d    = ones_q;
      bit_cnt_d = bit_cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      xor_d     = xor_q;
      buf_d     = buf_q;
      pkt_done  = 1'b0;
      frame_err = 1'b0;
      csum_err  = 1'b0;
      if (bad_half) begin
         state_d   = HUNT;
         ones_d    = '0;
         frame_err = (state_q != HUNT);
      end else begin
         case (state_q)
            HUNT: if (bit_v) begin
               if (bit_val) begin
                  ones_d = (ones_q == 5'd31) ? ones_q : ones_q + 5'd1;
               end else if (ones_q >= PRE_MIN) begin
                  state_d   = DATA;
                  ones_d    = '0;
                  idx_d     = '0;
                  bit_cnt_d = '0;
                  xor_d     = '0;
                  buf_d     = '0;
               end else begin
                  ones_d = '0;
               end
            end
            DATA: if (bit_v) begin
               shift_d   = {shift_q[6:0], bit_val};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7)
                  state_d = SEP;
            end
            SEP: if (bit_v) begin
               for (int b = 0; b < MAX_BYTES; b++)
                  if (idx_q == 3'(b))
                     buf_d[b*8 +: 8] = shift_q;
               xor_d     = xor_q ^ shift_q;
               idx_d     = idx_next;
               bit_cnt_d = '0;
               if (!bit_val) begin
                  if (idx_next == MAXB) begin
                     frame_err = 1'b1;
                     state_d   = HUNT;
                     ones_d    = '0;
                  end else begin
                     state_d = DATA;
                  end
               end else begin
                  // The end bit doubles as the first preamble bit of the next packet.
                  ones_d = 5'd1;
                  if (idx_next >= 3'd3 && xor_d == 8'h00) begin
                     pkt_done = 1'b1;
                     state_d  = HOLD;
                  end else begin
                     csum_err = 1'b1;
                     state_d  = HUNT;
                  end
               end
            end
            HOLD:    state_d = HUNT;
            default: state_d = HUNT;
         endcase
      end
   end

   // Single-entry output register; a same-cycle transfer frees it for the new packet.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_len_d   = out_len_q;
      load        = 1'b0;
      drop        = 1'b0;
      if (out_valid_q && pkt_ready)
         out_valid_d = 1'b0;
      if (pkt_done) begin
         if (!out_valid_q || pkt_ready) begin
            load        = 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = buf_d;
            out_len_d   = idx_next;
         end else begin
            drop = 1'b1;
         end
      end
      err_d = frame_err | csum_err | drop;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= HUNT;
         have_first_q <= 1'b0;
         first_q      <= HC_ONE;
         ones_q       <= '0;
         bit_cnt_q    <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         xor_q        <= '0;
         // NOTE: the byte buffer is reset too, so unused bytes of pkt_data always read zero.
         buf_q        <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_len_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         have_first_q <= have_first_d;
         first_q      <= first_d;
         ones_q       <= ones_d;
         bit_cnt_q    <= bit_cnt_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         xor_q        <= xor_d;
         buf_q        <= buf_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_len_q    <= out_len_d;
         err_q        <= err_d;
      end
   end

   assign pkt_valid = out_valid_q;
   assign pkt_data  = out_data_q;
   assign pkt_len   = out_len_q;
   assign err_pulse = err_q;

`ifdef DCC_DECODER_STATS_EN
   logic [15:0] good_q, good_d;
   logic [15:0] csum_cnt_q, csum_cnt_d;
   logic [15:0] frame_q, frame_d;

   always_comb begin
      good_d     = sat_inc16(good_q, load);
      csum_cnt_d = sat_inc16(csum_cnt_q, csum_err);
      frame_d    = sat_inc16(frame_q, frame_err | drop);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         good_q     <= '0;
         csum_cnt_q <= '0;
         frame_q    <= '0;
      end else begin
         good_q     <= good_d;
         csum_cnt_q <= csum_cnt_d;
         frame_q    <= frame_d;
      end
   end

   assign stat_good  = good_q;
   assign stat_csum  = csum_cnt_q;
   assign stat_frame = frame_q;
`endif

endmodule

// File: tb/tb_dcc_decoder.sv
// Directed bench for dcc_decoder: drives 58/100-cycle half-bits on track_in
// and compares outputs against hand-computed packets.
module tb_dcc_decoder;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        track_in = 1'b0;
   logic        pkt_ready = 1'b0;
   logic        pkt_valid;
   logic [47:0] pkt_data;
   logic [2:0]  pkt_len;
   logic        err_pulse;
`ifdef DCC_DECODER_STATS_EN
   logic [15:0] stat_good, stat_csum, stat_frame;
`endif

   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;
   int unsigned last_edge = 0;
   int          err_seen = 0;
   int          e0;

   dcc_decoder dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .track_in  (track_in),
      .pkt_valid (pkt_valid),
      .pkt_ready (pkt_ready),
      .pkt_data  (pkt_data),
      .pkt_len   (pkt_len),
      .err_pulse (err_pulse)
`ifdef DCC_DECODER_STATS_EN
      ,
      .stat_good  (stat_good),
      .stat_csum  (stat_csum),
      .stat_frame (stat_frame)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      if (err_pulse) err_seen++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Toggle the track once the current half has lasted n cycles.
   task automatic half(input int unsigned n);
      while (cyc - last_edge < n) @(negedge clk);
      track_in  = ~track_in;
      last_edge = cyc;
   endtask

   task automatic send_bit(input logic b);
      half(b ? 32'd58 : 32'd100);
      half(b ? 32'd58 : 32'd100);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   // A 75-cycle half first re-aligns the pairing while the decoder sits in HUNT.
   task automatic send_pkt(input int pre, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2);
      half(75);
      repeat (pre) send_bit(1'b1);
      send_bit(1'b0);
      send_byte(b0);
      send_bit(1'b0);
      send_byte(b1);
      send_bit(1'b0);
      send_byte(b2);
      send_bit(1'b1);
   endtask

   task automatic consume();
      pkt_ready = 1'b1;
      @(negedge clk);
      pkt_ready = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_valid", 64'(pkt_valid), 64'd0);
      check("rst_data",  64'(pkt_data),  64'd0);
      check("rst_len",   64'(pkt_len),   64'd0);
      check("rst_err",   64'(err_pulse), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      half(20);

      // Valid packet with exact 4-cycle latency
      e0 = err_seen;
      send_pkt(14, 8'h03, 8'h3F, 8'h3C);
      repeat (3) @(negedge clk);
      check("lat_early_valid", 64'(pkt_valid), 64'd0);
      @(negedge clk);
      check("lat4_valid", 64'(pkt_valid), 64'd1);
      check("good_len",   64'(pkt_len),   64'd3);
      check("good_data",  64'(pkt_data),  64'h3C3F03);
      check("good_noerr", 64'(err_seen - e0), 64'd0);
      consume();
      check("good_xfer", 64'(pkt_valid), 64'd0);

      // Bad checksum: one-cycle err_pulse 4 cycles after the last edge
      e0 = err_seen;
      send_pkt(14, 8'h03, 8'h3F, 8'h3D);
      repeat (3) @(negedge clk);
      check("csum_err_early", 64'(err_pulse), 64'd0);
      @(negedge clk);
      check("csum_err_pulse", 64'(err_pulse), 64'd1);
      @(negedge clk);
      check("csum_err_1cyc", 64'(err_pulse), 64'd0);
      @(negedge clk);
      check("csum_err_count", 64'(err_seen - e0), 64'd1);
      check("csum_no_valid",  64'(pkt_valid), 64'd0);

      // Short preamble (9 ones) is ignored; 10 ones is accepted
      e0 = err_seen;
      send_pkt(9, 8'h03, 8'h3F, 8'h3C);
      repeat (6) @(negedge clk);
      check("short_no_valid", 64'(pkt_valid), 64'd0);
      check("short_no_err",   64'(err_seen - e0), 64'd0);
      send_pkt(10, 8'h03, 8'h3F, 8'h3C);
      repeat (4) @(negedge clk);
      check("pre10_valid", 64'(pkt_valid), 64'd1);
      check("pre10_data",  64'(pkt_data),  64'h3C3F03);
      consume();

      // Backpressure: second packet dropped, first held stable
      send_pkt(14, 8'h03, 8'h3F, 8'h3C);
      repeat (4) @(negedge clk);
      check("bp_first_valid", 64'(pkt_valid), 64'd1);
      e0 = err_seen;
      send_pkt(14, 8'h01, 8'h02, 8'h03);
      repeat (6) @(negedge clk);
      check("bp_hold_valid", 64'(pkt_valid), 64'd1);
      check("bp_hold_data",  64'(pkt_data),  64'h3C3F03);
      check("bp_hold_len",   64'(pkt_len),   64'd3);
      check("bp_drop_err",   64'(err_seen - e0), 64'd1);
      consume();
      check("bp_xfer", 64'(pkt_valid), 64'd0);

      // Ready in the completion cycle: old packet leaves, new one loads, no error
      send_pkt(14, 8'h01, 8'h02, 8'h03);
      repeat (4) @(negedge clk);
      check("b_data", 64'(pkt_data), 64'h030201);
      e0 = err_seen;
      send_pkt(14, 8'h03, 8'h3F, 8'h3C);
      repeat (3) @(negedge clk);
      pkt_ready = 1'b1;
      @(negedge clk);
      pkt_ready = 1'b0;
      check("swap_valid", 64'(pkt_valid), 64'd1);
      check("swap_data",  64'(pkt_data),  64'h3C3F03);
      repeat (2) @(negedge clk);
      check("swap_noerr", 64'(err_seen - e0), 64'd0);
      consume();

      // 75-cycle half inside byte 2 aborts the packet
      e0 = err_seen;
      half(75);
      repeat (14) send_bit(1'b1);
      send_bit(1'b0);
      send_byte(8'h03);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      half(75);
      repeat (4) @(negedge clk);
      check("bad_err_pulse", 64'(err_pulse), 64'd1);
      @(negedge clk);
      check("bad_err_1cyc", 64'(err_pulse), 64'd0);
      @(negedge clk);
      check("bad_err_count", 64'(err_seen - e0), 64'd1);
      check("bad_no_valid",  64'(pkt_valid), 64'd0);
      send_pkt(14, 8'h03, 8'h3F, 8'h3C);
      repeat (4) @(negedge clk);
      check("after_bad_valid", 64'(pkt_valid), 64'd1);
      check("after_bad_data",  64'(pkt_data),  64'h3C3F03);

      // Async reset mid-byte with an unconsumed packet still in the output register
      half(75);
      repeat (14) send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_valid", 64'(pkt_valid), 64'd0);
      check("arst_data",  64'(pkt_data),  64'd0);
      check("arst_len",   64'(pkt_len),   64'd0);
      check("arst_err",   64'(err_pulse), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      e0 = err_seen;
      half(20);
      send_pkt(14, 8'h01, 8'h02, 8'h03);
      repeat (4) @(negedge clk);
      check("post_rst_valid", 64'(pkt_valid), 64'd1);
      check("post_rst_len",   64'(pkt_len),   64'd3);
      check("post_rst_data",  64'(pkt_data),  64'h030201);
      check("post_rst_noerr", 64'(err_seen - e0), 64'd0);
`ifdef DCC_DECODER_STATS_EN
      check("stat_good",  64'(stat_good),  64'd1);
      check("stat_frame", 64'(stat_frame), 64'd0);
`endif
      consume();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
